frac_div_monitor: RTL and testbench

Cycle-accurate monitor for the output of the fractional clock divider, placed directly downstream of it. The monitor samples the divided clock as a data signal in the source clock domain and measures each output period in source cycles. It sums those periods over a fixed window and flags any period or window sum that differs from the programmed fractional ratio (default 8.7 = 3×8 + 7×9 = 87 cycles per 10 periods). Its outputs drive the divider's self-test status and the period trace.

---
 rtl/frac_div_pkg.sv | 17 +
 rtl/fdm_period_cnt.sv | 38 +++
 rtl/frac_div_monitor.sv | 154 +++++++++++++++
 tb/tb_frac_div_monitor.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/frac_div_pkg.sv
// Shared fractional-divider ratio constants and monitor state type.
package frac_div_pkg;

    localparam int unsigned FDM_CNT_W   = 8;
    localparam int unsigned FDM_WIN     = 10;
    localparam int unsigned FDM_PER_LO  = 8;
    localparam int unsigned FDM_PER_HI  = 9;
    localparam int unsigned FDM_EXP_SUM = 87;
    localparam int unsigned FDM_SUM_W   = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2
    } fdm_state_t;

endpackage

// File: rtl/fdm_period_cnt.sv
// Edge detector on the sampled divider clock plus saturating period counter.
module fdm_period_cnt
    import frac_div_pkg::*;
#(
    parameter int unsigned CNT_W = FDM_CNT_W
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             div_clk,
    input  logic             clr,
    input  logic             inc,
    output logic             rise,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic div_d;

    assign rise = div_clk & ~div_d;
    assign sat  = (count == CNT_MAX);

    // Delayed copy of the divider clock for rising-edge detection
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) div_d <= 1'b0;
        else      div_d <= div_clk;
    end

    // Period counter: reload on a rise, otherwise count up and stick at max
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst)            count <= '0;
        else if (clr)        count <= '0;
        else if (rise)       count <= CNT_W'(1);
        else if (inc && !sat) count <= count + CNT_W'(1);
    end

endmodule

// File: rtl/frac_div_monitor.sv
// Period / window monitor for the fractional clock divider output.
// Optional duty-cycle check enabled by defining FDM_DUTY_CHECK_EN.
module frac_div_monitor
    import frac_div_pkg::*;
#(
    parameter int unsigned CNT_W   = FDM_CNT_W,
    parameter int unsigned WIN     = FDM_WIN,
    parameter int unsigned PER_LO  = FDM_PER_LO,
    parameter int unsigned PER_HI  = FDM_PER_HI,
    parameter int unsigned EXP_SUM = FDM_EXP_SUM,
    parameter int unsigned SUM_W   = FDM_SUM_W
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             div_clk,
    input  logic             clr_err,
    output logic [CNT_W-1:0] period,
    output logic             period_vld,
    output logic [SUM_W-1:0] win_sum,
    output logic             win_vld,
    output logic             err_period,
    output logic             err_sum,
`ifdef FDM_DUTY_CHECK_EN
    output logic [CNT_W-1:0] high_time,
    output logic             err_duty,
`endif
    output logic             armed
);

    localparam int unsigned WC_W = $clog2(WIN + 1);

    fdm_state_t       state, state_next;
    logic             rise, sat, cnt_clr_c, cnt_inc_c;
    logic [CNT_W-1:0] count;
    logic [SUM_W-1:0] acc, sum_c;
    logic [WC_W-1:0]  win_cnt;
    logic             strobe_c, last_c, win_done_c, perr_c, serr_c;

    fdm_period_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk_in  (clk_in),
        .rst     (rst),
        .div_clk (div_clk),
        .clr     (cnt_clr_c),
        .inc     (cnt_inc_c),
        .rise    (rise),
        .count   (count),
        .sat     (sat)
    );

    // State register
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Next state and per-cycle measurement decisions
    always_comb begin
        state_next = state;
        cnt_clr_c  = 1'b0;
        cnt_inc_c  = 1'b0;
        strobe_c   = 1'b0;
        case (state)
            IDLE: if (en) state_next = ARM;
            ARM:  if (rise) state_next = MEAS;
            MEAS: begin
                cnt_inc_c = 1'b1;
                strobe_c  = rise;
            end
            default: state_next = IDLE;
        endcase
        if (state == IDLE) cnt_clr_c = 1'b1;
        if (!en) begin
            state_next = IDLE;
            cnt_clr_c  = 1'b1;
            strobe_c   = 1'b0;
        end
    end

    assign last_c     = (win_cnt == WC_W'(WIN - 1));
    assign sum_c      = acc + SUM_W'(count);
    assign win_done_c = strobe_c & last_c;
    assign perr_c     = strobe_c & (sat | ((count != CNT_W'(PER_LO)) && (count != CNT_W'(PER_HI))));
    assign serr_c     = win_done_c & (sum_c != SUM_W'(EXP_SUM));

    // Registered outputs, window accumulator and sticky error flags
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            period     <= '0;
            period_vld <= 1'b0;
            win_sum    <= '0;
            win_vld    <= 1'b0;
            err_period <= 1'b0;
            err_sum    <= 1'b0;
            armed      <= 1'b0;
            acc        <= '0;
            win_cnt    <= '0;
        end else begin
            armed      <= (state_next == MEAS);
            period_vld <= strobe_c;
            win_vld    <= win_done_c;
            err_period <= (err_period & ~clr_err) | perr_c;
            err_sum    <= (err_sum & ~clr_err) | serr_c;
            if (strobe_c) period <= count;
            if (win_done_c) win_sum <= sum_c;
            if (!en || state == IDLE || win_done_c) begin
                acc     <= '0;
                win_cnt <= '0;
            end else if (strobe_c) begin
                acc     <= sum_c;
                win_cnt <= win_cnt + WC_W'(1);
            end
        end
    end

`ifdef FDM_DUTY_CHECK_EN
    localparam int unsigned HT_W = CNT_W + 1;
    localparam logic [CNT_W-1:0] HI_MAX = '1;

    logic             hi_run;
    logic [CNT_W-1:0] hi_cnt, hi_meas;
    logic             duty_bad_c;

    assign duty_bad_c = strobe_c & ((HT_W'(hi_meas) < HT_W'(2)) ||
                                    ((HT_W'(hi_meas) + HT_W'(2)) > HT_W'(count)));

    // High-time measurement from rise to fall, reported with the next period
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            hi_run    <= 1'b0;
            hi_cnt    <= '0;
            hi_meas   <= '0;
            high_time <= '0;
            err_duty  <= 1'b0;
        end else begin
            if (!en) begin
                hi_run <= 1'b0;
                hi_cnt <= '0;
            end else if (rise) begin
                hi_run <= 1'b1;
                hi_cnt <= CNT_W'(1);
            end else if (hi_run && div_clk) begin
                if (hi_cnt != HI_MAX) hi_cnt <= hi_cnt + CNT_W'(1);
            end else if (hi_run) begin
                hi_meas <= hi_cnt;
                hi_run  <= 1'b0;
            end
            if (strobe_c) high_time <= hi_meas;
            err_duty <= (err_duty & ~clr_err) | duty_bad_c;
        end
    end
`endif

endmodule

// File: tb/tb_frac_div_monitor.sv
// Self-checking bench for frac_div_monitor: timestamp-based reference model,
// per-cycle compare, directed scenarios and randomized divider patterns.
`timescale 1ns/1ps
module tb_frac_div_monitor;

    logic        clk_in = 1'b0;
    logic        rst, en, div_clk, clr_err;
    logic [7:0]  period;
    logic        period_vld;
    logic [11:0] win_sum;
    logic        win_vld, err_period, err_sum, armed;

    frac_div_monitor dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .en         (en),
        .div_clk    (div_clk),
        .clr_err    (clr_err),
        .period     (period),
        .period_vld (period_vld),
        .win_sum    (win_sum),
        .win_vld    (win_vld),
        .err_period (err_period),
        .err_sum    (err_sum),
        .armed      (armed)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: remembers the cycle of the last rise and the periods of
    // the open window, and derives each output from those.
    int  n_cyc, last_rise, m_sum, m_p;
    int  win_q[$];
    bit  m_armed, prev_div, en_prev, m_rise, m_npe, m_nse;
    int  exp_period, exp_win_sum;
    bit  exp_pvld, exp_wvld, exp_perr, exp_serr, exp_armed;

    always @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            n_cyc = 0; last_rise = 0; m_armed = 0; prev_div = 0; en_prev = 0;
            win_q.delete();
            exp_period = 0; exp_win_sum = 0; exp_pvld = 0; exp_wvld = 0;
            exp_perr = 0; exp_serr = 0; exp_armed = 0;
        end else begin
            m_rise = div_clk && !prev_div;
            exp_pvld = 0; exp_wvld = 0; m_npe = 0; m_nse = 0;
            if (!en) begin
                m_armed = 0;
                win_q.delete();
            end else if (en_prev && m_rise) begin
                if (m_armed) begin
                    m_p = n_cyc - last_rise;
                    if (m_p > 255) m_p = 255;
                    exp_period = m_p;
                    exp_pvld = 1;
                    m_npe = (m_p != 8) && (m_p != 9);
                    win_q.push_back(m_p);
                    if (win_q.size() == 10) begin
                        m_sum = 0;
                        foreach (win_q[i]) m_sum += win_q[i];
                        exp_win_sum = m_sum % 4096;
                        exp_wvld = 1;
                        m_nse = (exp_win_sum != 87);
                        win_q.delete();
                    end
                end
                m_armed = 1;
                last_rise = n_cyc;
            end
            exp_perr  = (exp_perr && !clr_err) || m_npe;
            exp_serr  = (exp_serr && !clr_err) || m_nse;
            exp_armed = m_armed;
            prev_div  = div_clk;
            en_prev   = en;
            n_cyc++;
        end
    end

    // Observation bookkeeping for directed expectations
    int pv_cnt = 0, wv_cnt = 0, last_period = 0, last_win = 0, bad_period = 0;
    int perr_at_bad = 0;

    // Per-cycle compare of every output against the model
    always @(negedge clk_in) begin
        chk("period",     int'(period),     exp_period);
        chk("period_vld", int'(period_vld), int'(exp_pvld));
        chk("win_sum",    int'(win_sum),    exp_win_sum);
        chk("win_vld",    int'(win_vld),    int'(exp_wvld));
        chk("err_period", int'(err_period), int'(exp_perr));
        chk("err_sum",    int'(err_sum),    int'(exp_serr));
        chk("armed",      int'(armed),      int'(exp_armed));
        if (period_vld) begin
            pv_cnt++;
            last_period = int'(period);
            if (period != 8'd8 && period != 8'd9) begin
                bad_period  = int'(period);
                perr_at_bad = int'(err_period);
            end
        end
        if (win_vld) begin
            wv_cnt++;
            last_win = int'(win_sum);
        end
    end

    // One divider period of p cycles (high for p/2), optional clr_err at the rise
    task automatic drive_one(input int p, input bit clr_rise);
        for (int c = 0; c < p; c++) begin
            div_clk = (c < p / 2);
            clr_err = clr_rise && (c == 0);
            @(negedge clk_in);
        end
        clr_err = 1'b0;
    endtask

    task automatic flush();
        en = 1'b0;
        @(negedge clk_in);
        en = 1'b1;
        @(negedge clk_in);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk_in);
        clr_err = 1'b0;
        @(negedge clk_in);
    endtask

    int pat[10] = '{8, 8, 9, 9, 8, 9, 9, 9, 9, 9};
    int ill[11] = '{8, 8, 9, 9, 10, 9, 9, 9, 9, 8, 8};
    int rp;
    bit rc;

    initial begin
        rst = 1'b0; en = 1'b0; div_clk = 1'b0; clr_err = 1'b0;
        repeat (3) @(negedge clk_in);
        chk("rst_period", int'(period), 0);
        chk("rst_win_sum", int'(win_sum), 0);
        chk("rst_pvld", int'(period_vld), 0);
        chk("rst_wvld", int'(win_vld), 0);
        chk("rst_err_period", int'(err_period), 0);
        chk("rst_err_sum", int'(err_sum), 0);
        chk("rst_armed", int'(armed), 0);
        rst = 1'b1;
        @(negedge clk_in);

        // Divider-style pattern, three repeats
        en = 1'b1;
        @(negedge clk_in);
        pv_cnt = 0; wv_cnt = 0;
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < 10; i++) drive_one(pat[i], 1'b0);
        repeat (3) @(negedge clk_in);
        chk("pattern_strobes", pv_cnt, 29);
        chk("pattern_windows", wv_cnt, 2);
        chk("pattern_win_sum", last_win, 87);
        chk("pattern_err_sum", int'(err_sum), 0);
        chk("pattern_err_period", int'(err_period), 0);

        // Illegal period of 10 inside one window
        flush();
        foreach (ill[i]) drive_one(ill[i], 1'b0);
        repeat (2) @(negedge clk_in);
        chk("illegal_period", bad_period, 10);
        chk("illegal_flag_at_strobe", perr_at_bad, 1);
        chk("illegal_win_sum", last_win, 88);
        chk("illegal_err_sum", int'(err_sum), 1);
        pulse_clr();
        chk("clr_err_period", int'(err_period), 0);
        chk("clr_err_sum", int'(err_sum), 0);

        // clr_err coincident with a period-7 error
        flush();
        drive_one(8, 1'b0);
        drive_one(7, 1'b0);
        drive_one(8, 1'b1);
        chk("simul_clr_period", bad_period, 7);
        chk("simul_clr_flag_at_strobe", perr_at_bad, 1);
        chk("simul_clr_flag_kept", int'(err_period), 1);

        // Mid-window disable, then a fresh window
        pulse_clr();
        flush();
        for (int i = 0; i < 5; i++) drive_one(pat[i], 1'b0);
        en = 1'b0;
        repeat (2) @(negedge clk_in);
        chk("disable_armed_low", int'(armed), 0);
        en = 1'b1;
        @(negedge clk_in);
        wv_cnt = 0;
        for (int i = 0; i < 10; i++) drive_one(pat[i], 1'b0);
        drive_one(8, 1'b0);
        chk("restart_windows", wv_cnt, 1);
        chk("restart_win_sum", last_win, 87);
        chk("restart_err_sum", int'(err_sum), 0);

        // Stuck-high divider clock saturates the counter
        div_clk = 1'b1;
        repeat (5) @(negedge clk_in);
        pv_cnt = 0;
        pulse_clr();
        repeat (293) @(negedge clk_in);
        chk("stuck_no_strobe", pv_cnt, 0);
        div_clk = 1'b0;
        repeat (4) @(negedge clk_in);
        drive_one(8, 1'b0);
        chk("stuck_period", last_period, 255);
        chk("stuck_err_period", int'(err_period), 1);

        // Randomized divider periods, clears and enable drops
        pulse_clr();
        flush();
        for (int k = 0; k < 300; k++) begin
            rp = ($urandom_range(0, 9) < 8) ? 8 + int'($urandom_range(0, 1))
                                            : int'($urandom_range(2, 20));
            rc = ($urandom_range(0, 7) == 0);
            drive_one(rp, rc);
            if ($urandom_range(0, 29) == 0) begin
                en = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk_in);
                en = 1'b1;
            end
        end

        // Asynchronous reset mid-window
        flush();
        drive_one(8, 1'b0);
        drive_one(9, 1'b0);
        drive_one(9, 1'b0);
        div_clk = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("arst_period", int'(period), 0);
        chk("arst_win_sum", int'(win_sum), 0);
        chk("arst_pvld", int'(period_vld), 0);
        chk("arst_wvld", int'(win_vld), 0);
        chk("arst_err_period", int'(err_period), 0);
        chk("arst_err_sum", int'(err_sum), 0);
        chk("arst_armed", int'(armed), 0);
        @(negedge clk_in);
        div_clk = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk_in);
        pv_cnt = 0;
        drive_one(8, 1'b0);
        chk("rearm_first_rise_no_period", pv_cnt, 0);
        drive_one(8, 1'b0);
        chk("rearm_second_rise_period", pv_cnt, 1);
        chk("rearm_period_value", last_period, 8);

        repeat (2) @(negedge clk_in);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
